// File: rtl/frame_config_writer.sv
// Frame-protocol config writer: assembles NumRows stream words into FrameData,
// then pulses one FrameStrobe line of a fabric column.
//
// state  | meaning
// Idle   | waiting for a header word (0xFAB0 in [31:16]); other words dropped
// Load   | capturing data beats into FrameData rows 0..NumRows-1
// Setup  | FrameData settling ahead of the strobe, SetupCycles long
// Strobe | one-hot FrameStrobe high for StrobeCycles
// Hold   | one quiet cycle with FrameData held before returning to Idle
module frame_config_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 16,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1
) (
  input  logic                                 UserCLK,
  input  logic                                 Reset,
  input  logic [31:0]                          s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 err,
  output logic [15:0]                          frames_written
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow   = RowW'(NumRows - 1);
  localparam logic [15:0]     SetupLoad  = 16'(SetupCycles - 1);
  localparam logic [15:0]     StrobeLoad = 16'(StrobeCycles - 1);
  localparam logic [15:0]     HeaderTag  = 16'hFAB0;

  typedef enum logic [2:0] {Idle, Load, Setup, Strobe, Hold} stateE;

  stateE                      state, stateNext;
  logic [15:0]                timer, timerNext;
  logic [RowW-1:0]            rowCnt, rowNext;
  logic [7:0]                 idx, idxNext;
  logic                       beat, beatLoad, errSet;
  logic [MaxFramesPerCol-1:0] strobeOneHot;

  assign beat = s_valid & s_ready;

  always_comb begin
    stateNext = state;
    timerNext = timer;
    rowNext   = rowCnt;
    idxNext   = idx;
    beatLoad  = 1'b0;
    errSet    = 1'b0;
    unique case (state)
      Idle: begin
        if (beat && s_data[31:16] == HeaderTag) begin
          idxNext   = s_data[7:0];
          rowNext   = '0;
          stateNext = Load;
        end
      end
      Load: begin
        if (beat) begin
          beatLoad = 1'b1;
          if (rowCnt == LastRow) begin
            rowNext = '0;
            if (32'(idx) < MaxFramesPerCol) begin
              stateNext = Setup;
              timerNext = SetupLoad;
            end else begin
              errSet    = 1'b1;
              stateNext = Idle;
            end
          end else begin
            rowNext = rowCnt + 1'b1;
          end
        end
      end
      Setup: begin
        if (timer == 16'd0) begin
          stateNext = Strobe;
          timerNext = StrobeLoad;
        end else begin
          timerNext = timer - 16'd1;
        end
      end
      Strobe: begin
        if (timer == 16'd0) stateNext = Hold;
        else                timerNext = timer - 16'd1;
      end
      Hold:    stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  // idx only changes in Idle, so it is stable whenever Strobe is entered.
  always_comb begin
    strobeOneHot = '0;
    for (int f = 0; f < MaxFramesPerCol; f++) begin
      if (32'(idx) == f) strobeOneHot[f] = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state          <= Idle;
      timer          <= '0;
      rowCnt         <= '0;
      idx            <= '0;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      busy           <= 1'b0;
      err            <= 1'b0;
      frames_written <= '0;
      s_ready        <= 1'b1;
    end else begin
      state       <= stateNext;
      timer       <= timerNext;
      rowCnt      <= rowNext;
      idx         <= idxNext;
      s_ready     <= (stateNext == Idle) || (stateNext == Load);
      busy        <= (stateNext != Idle);
      FrameStrobe <= (stateNext == Strobe) ? strobeOneHot : '0;
      if (errSet) err <= 1'b1;
      if (stateNext == Strobe && state != Strobe && frames_written != 16'hFFFF)
        frames_written <= frames_written + 16'd1;
      for (int r = 0; r < NumRows; r++) begin
        if (beatLoad && rowCnt == RowW'(r))
          FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
      end
    end
  end

endmodule
